imdct_bram_arbiter: RTL and testbench
=====================================

# imdct_bram_arbiter

Two-requester arbiter that shares a single IMDCT sample-buffer BRAM port between the host-side loader (AXI-lite driven) and the IMDCT compute core. It multiplexes en/addr/din/we onto the BRAM port and routes read data back with a one-cycle-latency valid tag. Round-robin with a bounded burst length keeps the host from starving the core while the core streams a frame. One instance sits in front of each of BRAM A and BRAM B.

## Interface
- WIDTH, 32, BRAM data width
- ADDRESS, 32, BRAM address width
- MAX_BURST, 16, max consecutive grants to one owner while the other requests (range 1..255)

- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- host_req  in  1  host access request, held with addr/we/din until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDRESS  host address
- host_din  in  WIDTH  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid on rdata
- core_req, core_we, core_addr, core_din  in  1/1/ADDRESS/WIDTH  same meaning for core
- core_gnt  out  1  core access accepted this cycle
- core_rvalid  out  1  core read data valid on rdata
- rdata  out  WIDTH  read data, equal to bram_dout, shared by both requesters
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDRESS  BRAM address
- bram_din  out  WIDTH  BRAM write data
- bram_dout  in  WIDTH  BRAM read data, valid one cycle after read-enabled cycle
- owner  out  2  00 idle, 01 host, 10 core (registered state)

## Operation
- State register: IDLE, HOST, CORE. Registers: last_owner (HOST/CORE), burst_cnt (8 bit), rd_tag (2 bit: host/core pending read).
- Grant is combinational from state and current requests; an access is accepted in the cycle gnt=1. At most one of host_gnt/core_gnt is high.
- IDLE: only one requests -> grant it, next state that owner. Both request -> grant the one that is not last_owner. None -> stay IDLE.
- HOST (CORE symmetric): owner req=1 and (other req=0 or burst_cnt < MAX_BURST) -> grant owner, burst_cnt+1 (saturates at 255). Owner req=1, other req=1, burst_cnt >= MAX_BURST -> grant other, switch state, burst_cnt=1. Owner req=0 -> grant other if requesting (switch, burst_cnt=1), else IDLE, burst_cnt=0.
- Every owner change or IDLE entry updates last_owner to the owner just left.
- bram_en=gnt_any; bram_we/addr/din copy the granted requester; all four are 0 when no grant.
- Read accepted (gnt & !we): rd_tag next = requester; else rd_tag next = 0. host_rvalid=rd_tag[0], core_rvalid=rd_tag[1]. rdata=bram_dout unconditionally.
- Writes return no response.

## Timing
- Grant latency 0: request seen with free/owned port is granted same cycle.
- Read latency: rvalid exactly 1 cycle after the granted cycle; back-to-back reads give rvalid every cycle.
- Switch on burst limit: the cycle burst_cnt >= MAX_BURST and the other requests, the other is granted that same cycle; no idle bubble.
- Reset: state IDLE, last_owner=CORE (host wins first tie), burst_cnt=0, rd_tag=0; owner=00, all gnt/rvalid/bram_* = 0 while reset is high and in the first cycle after only requests drive outputs.
- Reset mid-read: pending rd_tag cleared; no rvalid issued for the interrupted read.
- Requests changing while not granted are legal; requester must hold until gnt.

## Test plan
- Reset then host_req=1 read addr 0x10 alone -> host_gnt same cycle, bram_en=1, bram_addr=0x10, bram_we=0; next cycle host_rvalid=1, rdata=BRAM contents, core_rvalid=0.
- Both request from IDLE after reset -> host granted first; host drops req -> core granted same cycle, owner=10.
- MAX_BURST=4, host holds req with core requesting -> host granted 4 cycles, 5th cycle core_gnt=1, no bubble, host resumes only after core limit/drop.
- Core alone streams 300 reads -> core_gnt every cycle (burst_cnt saturates at 255), core_rvalid every cycle one cycle delayed.
- Host write 0xDEADBEEF to 0x4 then core read 0x4 next cycle -> bram_we=1/din=0xDEADBEEF, then core_rvalid with rdata=0xDEADBEEF.
- Assert reset the cycle after a granted core read -> core_rvalid stays 0, owner=00, all bram_* = 0.

Source files
------------

// File: rtl/imdct_bram_arbiter_if.sv
// Bundle of both requester ports and the shared BRAM port of one IMDCT buffer arbiter.
// The slave modport is the arbiter view; master is the requesters/BRAM view.
interface imdct_bram_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDRESS = 32
);
  logic               host_req;
  logic               host_we;
  logic [ADDRESS-1:0] host_addr;
  logic [WIDTH-1:0]   host_din;
  logic               host_gnt;
  logic               host_rvalid;

  logic               core_req;
  logic               core_we;
  logic [ADDRESS-1:0] core_addr;
  logic [WIDTH-1:0]   core_din;
  logic               core_gnt;
  logic               core_rvalid;

  logic [WIDTH-1:0]   rdata;
  logic               bram_en;
  logic               bram_we;
  logic [ADDRESS-1:0] bram_addr;
  logic [WIDTH-1:0]   bram_din;
  logic [WIDTH-1:0]   bram_dout;
  logic [1:0]         owner;

  modport slave (
    input  host_req, host_we, host_addr, host_din,
    input  core_req, core_we, core_addr, core_din,
    input  bram_dout,
    output host_gnt, host_rvalid, core_gnt, core_rvalid,
    output rdata, bram_en, bram_we, bram_addr, bram_din, owner
  );

  modport master (
    output host_req, host_we, host_addr, host_din,
    output core_req, core_we, core_addr, core_din,
    output bram_dout,
    input  host_gnt, host_rvalid, core_gnt, core_rvalid,
    input  rdata, bram_en, bram_we, bram_addr, bram_din, owner
  );
endinterface

// File: rtl/imdct_bram_arbiter.sv
// Round-robin, burst-limited arbiter sharing one IMDCT sample BRAM port between
// the host loader and the IMDCT core; grants are same-cycle, read valid one cycle later.
module imdct_bram_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDRESS   = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  imdct_bram_arbiter_if.slave  bus
);
  localparam int unsigned BURST_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOST = 2'b01,
    S_CORE = 2'b10
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_last_core, w_last_core_nxt;
  logic [BURST_W-1:0]   r_burst_cnt, w_burst_nxt, w_burst_inc;
  logic [1:0]           r_rd_tag;
  logic                 w_host_gnt, w_core_gnt;
  logic                 w_bram_en, w_bram_we;
  logic [ADDRESS-1:0]   w_bram_addr;
  logic [WIDTH-1:0]     w_bram_din;
  logic                 w_under_limit;

  assign w_burst_inc   = (r_burst_cnt == '1) ? r_burst_cnt : r_burst_cnt + BURST_W'(1);
  assign w_under_limit = (r_burst_cnt < BURST_W'(MAX_BURST));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_last_core <= 1'b1;
      r_burst_cnt <= '0;
      r_rd_tag    <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_last_core <= w_last_core_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_rd_tag    <= {w_core_gnt & ~bus.core_we, w_host_gnt & ~bus.host_we};
    end
  end

  // Next owner and grant; leaving an owner always records it as last_owner.
  always_comb begin
    w_host_gnt      = 1'b0;
    w_core_gnt      = 1'b0;
    w_state_nxt     = r_state;
    w_last_core_nxt = r_last_core;
    w_burst_nxt     = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.host_req && (!bus.core_req || r_last_core)) begin
          w_host_gnt  = 1'b1;
          w_state_nxt = S_HOST;
          w_burst_nxt = BURST_W'(1);
        end else if (bus.core_req) begin
          w_core_gnt  = 1'b1;
          w_state_nxt = S_CORE;
          w_burst_nxt = BURST_W'(1);
        end
      end
      S_HOST: begin
        if (bus.host_req && (!bus.core_req || w_under_limit)) begin
          w_host_gnt  = 1'b1;
          w_burst_nxt = w_burst_inc;
        end else if (bus.core_req) begin
          w_core_gnt      = 1'b1;
          w_state_nxt     = S_CORE;
          w_burst_nxt     = BURST_W'(1);
          w_last_core_nxt = 1'b0;
        end else begin
          w_state_nxt     = S_IDLE;
          w_burst_nxt     = '0;
          w_last_core_nxt = 1'b0;
        end
      end
      S_CORE: begin
        if (bus.core_req && (!bus.host_req || w_under_limit)) begin
          w_core_gnt  = 1'b1;
          w_burst_nxt = w_burst_inc;
        end else if (bus.host_req) begin
          w_host_gnt      = 1'b1;
          w_state_nxt     = S_HOST;
          w_burst_nxt     = BURST_W'(1);
          w_last_core_nxt = 1'b1;
        end else begin
          w_state_nxt     = S_IDLE;
          w_burst_nxt     = '0;
          w_last_core_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // No access may reach the BRAM while reset is held.
    if (i_reset) begin
      w_host_gnt = 1'b0;
      w_core_gnt = 1'b0;
    end
  end

  // BRAM port copies the granted requester, otherwise all zero.
  always_comb begin
    w_bram_en   = 1'b0;
    w_bram_we   = 1'b0;
    w_bram_addr = '0;
    w_bram_din  = '0;
    if (w_host_gnt) begin
      w_bram_en   = 1'b1;
      w_bram_we   = bus.host_we;
      w_bram_addr = bus.host_addr;
      w_bram_din  = bus.host_din;
    end else if (w_core_gnt) begin
      w_bram_en   = 1'b1;
      w_bram_we   = bus.core_we;
      w_bram_addr = bus.core_addr;
      w_bram_din  = bus.core_din;
    end
  end

  assign bus.host_gnt    = w_host_gnt;
  assign bus.core_gnt    = w_core_gnt;
  assign bus.host_rvalid = r_rd_tag[0] & ~i_reset;
  assign bus.core_rvalid = r_rd_tag[1] & ~i_reset;
  assign bus.owner       = i_reset ? 2'b00 : r_state;
  assign bus.rdata       = bus.bram_dout;
  assign bus.bram_en     = w_bram_en;
  assign bus.bram_we     = w_bram_we;
  assign bus.bram_addr   = w_bram_addr;
  assign bus.bram_din    = w_bram_din;
endmodule

// File: tb/tb_imdct_bram_arbiter.sv
// Directed bench for imdct_bram_arbiter with MAX_BURST=4 and a read-first BRAM model
// preloaded with 0xA5000000 + address.
module tb_imdct_bram_arbiter;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ADDRESS   = 32;
  localparam int unsigned MAX_BURST = 4;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_fail;
  logic [WIDTH-1:0] mem [256];

  imdct_bram_arbiter_if #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) bus ();

  imdct_bram_arbiter #(
    .WIDTH(WIDTH), .ADDRESS(ADDRESS), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous BRAM.
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr[7:0]] <= bus.bram_din;
      bus.bram_dout <= mem[bus.bram_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic host_drive(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] din);
    bus.host_req = req; bus.host_we = we; bus.host_addr = addr; bus.host_din = din;
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] din);
    bus.core_req = req; bus.core_we = we; bus.core_addr = addr; bus.core_din = din;
  endtask

  initial begin
    int bad_gnt;
    int bad_rv;
    n_pass = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
    bus.bram_dout = '0;
    rst = 1'b1;
    host_drive(1'b1, 1'b0, 32'h10, 32'h0);
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Requests are ignored while reset is high.
    tick(); sample();
    chk("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
    chk("rst_bram_en",  32'(bus.bram_en), 32'd0);
    chk("rst_owner",    32'(bus.owner), 32'd0);
    chk("rst_host_rv",  32'(bus.host_rvalid), 32'd0);

    // Lone host read of 0x10.
    tick(); rst = 1'b0; sample();
    chk("h_rd_gnt",   32'(bus.host_gnt), 32'd1);
    chk("h_rd_en",    32'(bus.bram_en), 32'd1);
    chk("h_rd_addr",  bus.bram_addr, 32'h10);
    chk("h_rd_we",    32'(bus.bram_we), 32'd0);
    chk("h_rd_cgnt",  32'(bus.core_gnt), 32'd0);
    chk("h_rd_owner0", 32'(bus.owner), 32'd0);
    tick(); host_drive(1'b0, 1'b0, 32'h0, 32'h0); sample();
    chk("h_rd_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("h_rd_rdata",  bus.rdata, 32'hA500_0010);
    chk("h_rd_crv",    32'(bus.core_rvalid), 32'd0);
    chk("h_rd_owner1", 32'(bus.owner), 32'd1);
    chk("h_rd_idle_en", 32'(bus.bram_en), 32'd0);

    // Tie after reset goes to host; host drop hands over to core same cycle.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    host_drive(1'b1, 1'b0, 32'h20, 32'h0);
    core_drive(1'b1, 1'b0, 32'h30, 32'h0);
    sample();
    chk("tie_hgnt", 32'(bus.host_gnt), 32'd1);
    chk("tie_cgnt", 32'(bus.core_gnt), 32'd0);
    chk("tie_addr", bus.bram_addr, 32'h20);
    tick(); host_drive(1'b0, 1'b0, 32'h0, 32'h0); sample();
    chk("hand_cgnt",  32'(bus.core_gnt), 32'd1);
    chk("hand_hgnt",  32'(bus.host_gnt), 32'd0);
    chk("hand_addr",  bus.bram_addr, 32'h30);
    chk("hand_hrv",   32'(bus.host_rvalid), 32'd1);
    chk("hand_rdata", bus.rdata, 32'hA500_0020);
    tick(); core_drive(1'b0, 1'b0, 32'h0, 32'h0); sample();
    chk("hand_owner", 32'(bus.owner), 32'd2);
    chk("hand_crv",   32'(bus.core_rvalid), 32'd1);
    chk("hand_rdata2", bus.rdata, 32'hA500_0030);

    // Burst limit: host 4 grants, then core 4, then host, with no bubble.
    tick();
    host_drive(1'b1, 1'b0, 32'h01, 32'h0);
    core_drive(1'b1, 1'b0, 32'h02, 32'h0);
    sample();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin tick(); sample(); end
      chk($sformatf("burst_h%0d", k), {30'd0, bus.core_gnt, bus.host_gnt}, 32'd1);
    end
    tick(); sample();
    chk("burst_sw_c", {30'd0, bus.core_gnt, bus.host_gnt}, 32'd2);
    chk("burst_sw_addr", bus.bram_addr, 32'h02);
    chk("burst_sw_hrv", 32'(bus.host_rvalid), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick(); sample();
      chk($sformatf("burst_c%0d", k), {30'd0, bus.core_gnt, bus.host_gnt}, 32'd2);
    end
    tick(); sample();
    chk("burst_back_h", {30'd0, bus.core_gnt, bus.host_gnt}, 32'd1);
    chk("burst_back_crv", 32'(bus.core_rvalid), 32'd1);
    chk("burst_back_rdata", bus.rdata, 32'hA500_0002);
    tick();
    host_drive(1'b0, 1'b0, 32'h0, 32'h0);
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("burst_end_en", 32'(bus.bram_en), 32'd0);
    chk("burst_end_hrv", 32'(bus.host_rvalid), 32'd1);

    // Core streams 300 reads alone: grant and rvalid every cycle.
    bad_gnt = 0;
    bad_rv  = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      core_drive(1'b1, 1'b0, 32'(i % 256), 32'h0);
      sample();
      if (bus.core_gnt !== 1'b1 || bus.bram_addr !== 32'(i % 256)) bad_gnt++;
      if (i > 0 && (bus.core_rvalid !== 1'b1 || bus.rdata !== 32'hA500_0000 + 32'((i - 1) % 256)))
        bad_rv++;
    end
    chk("stream_gnt_bad", 32'(bad_gnt), 32'd0);
    chk("stream_rv_bad",  32'(bad_rv), 32'd0);
    chk("stream_owner",   32'(bus.owner), 32'd2);
    tick(); core_drive(1'b0, 1'b0, 32'h0, 32'h0); sample();
    chk("stream_last_rv",    32'(bus.core_rvalid), 32'd1);
    chk("stream_last_rdata", bus.rdata, 32'hA500_0000 + 32'(299 % 256));

    // Host write then core read-back of the same word.
    tick(); host_drive(1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF); sample();
    chk("wr_hgnt", 32'(bus.host_gnt), 32'd1);
    chk("wr_we",   32'(bus.bram_we), 32'd1);
    chk("wr_addr", bus.bram_addr, 32'h4);
    chk("wr_din",  bus.bram_din, 32'hDEAD_BEEF);
    tick();
    host_drive(1'b0, 1'b0, 32'h0, 32'h0);
    core_drive(1'b1, 1'b0, 32'h4, 32'h0);
    sample();
    chk("rb_cgnt",   32'(bus.core_gnt), 32'd1);
    chk("rb_we",     32'(bus.bram_we), 32'd0);
    chk("rb_no_hrv", 32'(bus.host_rvalid), 32'd0);
    tick(); core_drive(1'b0, 1'b0, 32'h0, 32'h0); sample();
    chk("rb_crv",   32'(bus.core_rvalid), 32'd1);
    chk("rb_rdata", bus.rdata, 32'hDEAD_BEEF);

    // Reset right after a granted core read drops its response.
    tick(); core_drive(1'b1, 1'b0, 32'h8, 32'h0); sample();
    chk("mr_cgnt", 32'(bus.core_gnt), 32'd1);
    tick(); rst = 1'b1; core_drive(1'b0, 1'b0, 32'h0, 32'h0); sample();
    chk("mr_crv",   32'(bus.core_rvalid), 32'd0);
    chk("mr_owner", 32'(bus.owner), 32'd0);
    chk("mr_bram",  {bus.bram_en, bus.bram_we, 30'd0} | bus.bram_addr | bus.bram_din, 32'd0);
    tick(); rst = 1'b0; sample();
    chk("mr_crv_after",   32'(bus.core_rvalid), 32'd0);
    chk("mr_owner_after", 32'(bus.owner), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
